// File: rtl/sfr_bank_ta_pkg.sv
// Shared constants for the timed-access SFR bank: SFR addresses, TA unlock keys
// and the TA state encoding.
package sfr_bank_ta_pkg;

   localparam logic [7:0] SFR_B   = 8'hF0;
   localparam logic [7:0] SFR_TA  = 8'hC7;
   localparam logic [7:0] TA_KEY1 = 8'hAA;
   localparam logic [7:0] TA_KEY2 = 8'h55;
   localparam int         TA_CNT_W = 4;

   typedef enum logic [1:0] {
      TA_IDLE  = 2'd0,
      TA_ARMED = 2'd1,
      TA_OPEN  = 2'd2
   } ta_state_e;

   // Register idx of a bank lives at the idx-th 8-aligned byte above base.
   function automatic logic [7:0] sfr_addr(input logic [7:0] base, input int idx);
      return base + 8'(idx * 8);
   endfunction

endpackage

// File: rtl/sfr_bank_ta_if.sv
// SFR write/read bus between the core's SFR block and a register bank.
interface sfr_bank_ta_if;

   logic [7:0] data_in;
   logic [7:0] addr;
   logic       wr_en;
   logic       wr_bit_en;
   logic       bit_in;
   logic [7:0] rd_addr;
   logic [7:0] rd_data;

   modport master (
      output data_in, addr, wr_en, wr_bit_en, bit_in, rd_addr,
      input  rd_data
   );

   modport slave (
      input  data_in, addr, wr_en, wr_bit_en, bit_in, rd_addr,
      output rd_data
   );

endinterface

// File: rtl/sfr_ta_unlock.sv
// Timed-access unlock FSM: 0xAA then 0x55 to the TA register opens a write
// window of TA_WINDOW cycles for protected SFRs.
module sfr_ta_unlock
   import sfr_bank_ta_pkg::*;
#(
   parameter int TA_WINDOW = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ta_wr,
   input  logic [7:0] data_in,
   input  logic       prot_wr_accepted,
   output logic       ta_open
);

   localparam logic [TA_CNT_W-1:0] CNT_LOAD = TA_CNT_W'(TA_WINDOW - 1);

   ta_state_e           state;
   logic [TA_CNT_W-1:0] cnt;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= TA_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            TA_IDLE: begin
               if (ta_wr && data_in == TA_KEY1) begin
                  state <= TA_ARMED;
                  cnt   <= CNT_LOAD;
               end
            end
            TA_ARMED: begin
               if (ta_wr) begin
                  if (data_in == TA_KEY2) begin
                     state <= TA_OPEN;
                     cnt   <= CNT_LOAD;
                  end else if (data_in == TA_KEY1) begin
                     cnt   <= CNT_LOAD;
                  end else begin
                     state <= TA_IDLE;
                  end
               end else if (cnt == '0) begin
                  state <= TA_IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            TA_OPEN: begin
               // A single accepted protected write consumes the window.
               if (prot_wr_accepted) begin
                  state <= TA_IDLE;
               end else if (ta_wr) begin
                  if (data_in == TA_KEY1) begin
                     state <= TA_ARMED;
                     cnt   <= CNT_LOAD;
                  end else begin
                     state <= TA_IDLE;
                  end
               end else if (cnt == '0) begin
                  state <= TA_IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: state <= TA_IDLE;
         endcase
      end
   end

   assign ta_open = (state == TA_OPEN);

endmodule

// File: rtl/sfr_bank_ta.sv
// Bank of bit-addressable 8-bit SFRs with byte/bit writes, a registered read
// port and timed-access protection for the registers flagged in PROT_MASK.
module sfr_bank_ta
   import sfr_bank_ta_pkg::*;
#(
   parameter int                      NUM_REGS  = 4,
   parameter logic [7:0]              BASE_ADDR = SFR_B,
   parameter logic [NUM_REGS-1:0]     PROT_MASK = 4'b0010,
   parameter logic [8*NUM_REGS-1:0]   RESET_VAL = '0,
   parameter logic [7:0]              TA_ADDR   = SFR_TA,
   parameter int                      TA_WINDOW = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   sfr_bank_ta_if.slave          bus,
   output logic [8*NUM_REGS-1:0] regs_out,
   output logic                  ta_open,
   output logic                  ta_viol
);

   logic [7:0]          regs [NUM_REGS];
   logic [NUM_REGS-1:0] byte_hit;
   logic [NUM_REGS-1:0] bit_hit;
   logic                prot_hit;
   logic                prot_accepted;
   logic                ta_wr;
   logic [7:0]          rd_next;
   logic [7:0]          rd_reg;
   logic [7:0]          reg_addr;

   assign ta_wr = bus.wr_en && !bus.wr_bit_en && (bus.addr == TA_ADDR);

   // Write decode and read mux both see the pre-write register contents.
   always_comb begin
      byte_hit = '0;
      bit_hit  = '0;
      prot_hit = 1'b0;
      rd_next  = 8'h00;
      reg_addr = 8'h00;
      for (int i = 0; i < NUM_REGS; i++) begin
         reg_addr    = sfr_addr(BASE_ADDR, i);
         byte_hit[i] = bus.wr_en && !bus.wr_bit_en && (bus.addr == reg_addr);
         bit_hit[i]  = bus.wr_en && bus.wr_bit_en && (bus.addr[7:3] == reg_addr[7:3]);
         if (PROT_MASK[i] && (byte_hit[i] || bit_hit[i]))
            prot_hit = 1'b1;
         if (bus.rd_addr == reg_addr)
            rd_next = regs[i];
      end
      if (bus.rd_addr == TA_ADDR)
         rd_next = {7'b0, ta_open};
   end

   assign prot_accepted = prot_hit && ta_open;

   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REGS; i++)
            regs[i] <= RESET_VAL[8*i +: 8];
         rd_reg  <= 8'h00;
         ta_viol <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (!PROT_MASK[i] || ta_open) begin
               if (byte_hit[i])
                  regs[i] <= bus.data_in;
               else if (bit_hit[i])
                  regs[i][bus.addr[2:0]] <= bus.bit_in;
            end
         end
         rd_reg  <= rd_next;
         ta_viol <= prot_hit && !ta_open;
      end
   end

   assign bus.rd_data = rd_reg;

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign regs_out[8*g +: 8] = regs[g];
   end

   sfr_ta_unlock #(
      .TA_WINDOW (TA_WINDOW)
   ) u_unlock (
      .clock            (clock),
      .reset            (reset),
      .ta_wr            (ta_wr),
      .data_in          (bus.data_in),
      .prot_wr_accepted (prot_accepted),
      .ta_open          (ta_open)
   );

endmodule

// File: tb/tb_sfr_bank_ta.sv
// Self-checking bench for sfr_bank_ta: directed vector table, hand-written TA
// timing sequences and randomized traffic against a behavioural model.
module tb_sfr_bank_ta;

   localparam int          NR   = 4;
   localparam logic [7:0]  BASE = 8'hE0;
   localparam logic [3:0]  PROT = 4'b1000;
   localparam logic [31:0] RV   = 32'h33441122;
   localparam logic [7:0]  TA   = 8'hC7;
   localparam int          W    = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] regs_out;
   logic        ta_open;
   logic        ta_viol;

   always #5 clock = ~clock;

   sfr_bank_ta_if bus();

   sfr_bank_ta #(
      .NUM_REGS  (NR),
      .BASE_ADDR (BASE),
      .PROT_MASK (PROT),
      .RESET_VAL (RV),
      .TA_ADDR   (TA),
      .TA_WINDOW (W)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .bus      (bus),
      .regs_out (regs_out),
      .ta_open  (ta_open),
      .ta_viol  (ta_viol)
   );

   int tests = 0;
   int fails = 0;

   // Model: register contents plus the last cycle index (inclusive) in which
   // the bank is armed / open; cyc is the index of the current clock cycle.
   logic [7:0] m_regs [NR];
   int         armed_until = -1;
   int         open_until  = -1;
   int         cyc = 0;

   function automatic logic [7:0] addr_of(input int i);
      return 8'(BASE + 8 * i);
   endfunction

   function automatic logic [31:0] m_flat();
      return {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
   endfunction

   function automatic logic m_open(input int c);
      return c <= open_until;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic rst, input logic we, input logic be,
                        input logic [7:0] a, input logic [7:0] d, input logic b,
                        input logic [7:0] ra);
      int         c;
      int         idx;
      logic [7:0] rd_n;
      logic       viol_n;
      c = cyc;
      reset         = rst;
      bus.wr_en     = we;
      bus.wr_bit_en = be;
      bus.addr      = a;
      bus.data_in   = d;
      bus.bit_in    = b;
      bus.rd_addr   = ra;

      rd_n = 8'h00;
      if (ra == TA) rd_n = {7'b0, m_open(c)};
      for (int i = 0; i < NR; i++)
         if (ra == addr_of(i)) rd_n = m_regs[i];

      idx = -1;
      viol_n = 1'b0;
      if (we)
         for (int i = 0; i < NR; i++)
            if ((!be && a == addr_of(i)) || (be && (a & 8'hF8) == addr_of(i))) idx = i;
      if (idx >= 0) begin
         if (PROT[idx] && !m_open(c)) begin
            viol_n = 1'b1;
         end else begin
            if (be) m_regs[idx][a[2:0]] = b;
            else    m_regs[idx] = d;
            if (PROT[idx]) open_until = -1;
         end
      end
      if (we && !be && a == TA) begin
         if (d == 8'hAA) begin
            armed_until = c + W;
            open_until  = -1;
         end else if (d == 8'h55 && c <= armed_until) begin
            open_until  = c + W;
            armed_until = -1;
         end else begin
            armed_until = -1;
            open_until  = -1;
         end
      end
      if (!rst) begin
         for (int i = 0; i < NR; i++) m_regs[i] = RV[8*i +: 8];
         armed_until = -1;
         open_until  = -1;
         rd_n   = 8'h00;
         viol_n = 1'b0;
      end

      @(posedge clock);
      #1;
      cyc++;
      check("model_regs_out", regs_out, m_flat());
      check("model_ta_open", {31'b0, ta_open}, {31'b0, m_open(cyc)});
      check("model_rd_data", {24'b0, bus.rd_data}, {24'b0, rd_n});
      check("model_ta_viol", {31'b0, ta_viol}, {31'b0, viol_n});
   endtask

   task automatic idle(input logic [7:0] ra);
      drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, ra);
   endtask

   task automatic ta_write(input logic [7:0] d);
      drive(1'b1, 1'b1, 1'b0, TA, d, 1'b0, TA);
   endtask

   typedef struct {
      logic        we;
      logic        be;
      logic [7:0]  a;
      logic [7:0]  d;
      logic        b;
      logic [7:0]  ra;
      logic [7:0]  x_rd;
      logic [31:0] x_regs;
      logic        x_open;
      logic        x_viol;
   } vec_t;

   vec_t tbl [16];

   initial begin
      logic [7:0] a, d, ra;
      logic [1:0] pick;
      int         r;
      logic       open_seq [4];

      tbl[0]  = '{1'b1, 1'b0, 8'hF0, 8'h5A, 1'b0, 8'hF0, 8'h44, 32'h335A1122, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'hF0, 8'h5A, 32'h335A1122, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 1'b0, 8'hF0, 8'h00, 1'b0, 8'hE0, 8'h22, 32'h33001122, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 1'b1, 8'hF3, 8'h00, 1'b1, 8'hF0, 8'h00, 32'h33081122, 1'b0, 1'b0};
      tbl[4]  = '{1'b1, 1'b0, 8'hE8, 8'hFF, 1'b0, 8'hF0, 8'h08, 32'h3308FF22, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, 1'b1, 8'hEA, 8'h00, 1'b0, 8'hE8, 8'hFF, 32'h3308FB22, 1'b0, 1'b0};
      tbl[6]  = '{1'b1, 1'b0, 8'h80, 8'h99, 1'b0, 8'hE8, 8'hFB, 32'h3308FB22, 1'b0, 1'b0};
      tbl[7]  = '{1'b1, 1'b0, 8'hF8, 8'h77, 1'b0, 8'hF8, 8'h33, 32'h3308FB22, 1'b0, 1'b1};
      tbl[8]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h80, 8'h00, 32'h3308FB22, 1'b0, 1'b0};
      tbl[9]  = '{1'b1, 1'b1, 8'hF9, 8'h00, 1'b0, 8'hC7, 8'h00, 32'h3308FB22, 1'b0, 1'b1};
      tbl[10] = '{1'b1, 1'b1, 8'hC7, 8'h00, 1'b1, 8'hF8, 8'h33, 32'h3308FB22, 1'b0, 1'b0};
      tbl[11] = '{1'b1, 1'b0, 8'hC7, 8'hAA, 1'b0, 8'hC7, 8'h00, 32'h3308FB22, 1'b0, 1'b0};
      tbl[12] = '{1'b1, 1'b0, 8'hC7, 8'h55, 1'b0, 8'hC7, 8'h00, 32'h3308FB22, 1'b1, 1'b0};
      tbl[13] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'hC7, 8'h01, 32'h3308FB22, 1'b1, 1'b0};
      tbl[14] = '{1'b1, 1'b0, 8'hF8, 8'h77, 1'b0, 8'hF8, 8'h33, 32'h7708FB22, 1'b0, 1'b0};
      tbl[15] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'hF8, 8'h77, 32'h7708FB22, 1'b0, 1'b0};

      // Reset held for two cycles, with a write pending that must be ignored.
      drive(1'b0, 1'b1, 1'b0, 8'hF0, 8'hEE, 1'b0, 8'hF0);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'hF0);
      check("reset_regs_out", regs_out, 32'h33441122);
      check("reset_ta_open", {31'b0, ta_open}, 32'd0);
      check("reset_rd_data", {24'b0, bus.rd_data}, 32'd0);
      check("reset_ta_viol", {31'b0, ta_viol}, 32'd0);

      for (int k = 0; k < 16; k++) begin
         drive(1'b1, tbl[k].we, tbl[k].be, tbl[k].a, tbl[k].d, tbl[k].b, tbl[k].ra);
         check($sformatf("row%0d_rd_data", k), {24'b0, bus.rd_data}, {24'b0, tbl[k].x_rd});
         check($sformatf("row%0d_regs_out", k), regs_out, tbl[k].x_regs);
         check($sformatf("row%0d_ta_open", k), {31'b0, ta_open}, {31'b0, tbl[k].x_open});
         check($sformatf("row%0d_ta_viol", k), {31'b0, ta_viol}, {31'b0, tbl[k].x_viol});
      end

      // Key 2 arriving five cycles after key 1 is too late.
      ta_write(8'hAA);
      for (int k = 0; k < 4; k++) idle(TA);
      ta_write(8'h55);
      check("late_key_no_open", {31'b0, ta_open}, 32'd0);
      drive(1'b1, 1'b1, 1'b0, 8'hF8, 8'h66, 1'b0, 8'hF8);
      check("late_key_viol", {31'b0, ta_viol}, 32'd1);
      check("late_key_reg_kept", {24'b0, regs_out[31:24]}, 32'h77);

      // Window stays open for exactly W cycles after the key 2 write.
      ta_write(8'hAA);
      ta_write(8'h55);
      check("window_c1", {31'b0, ta_open}, 32'd1);
      open_seq = '{1'b1, 1'b1, 1'b1, 1'b0};
      for (int k = 0; k < 4; k++) begin
         idle(TA);
         check($sformatf("window_c%0d", k + 2), {31'b0, ta_open}, {31'b0, open_seq[k]});
      end
      drive(1'b1, 1'b1, 1'b0, 8'hF8, 8'h66, 1'b0, 8'hF8);
      check("expired_viol", {31'b0, ta_viol}, 32'd1);
      check("expired_reg_kept", {24'b0, regs_out[31:24]}, 32'h77);

      // Reset in the middle of an open window.
      ta_write(8'hAA);
      ta_write(8'h55);
      idle(TA);
      check("pre_reset_open", {31'b0, ta_open}, 32'd1);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, TA);
      check("mid_reset_closed", {31'b0, ta_open}, 32'd0);
      check("mid_reset_regs", regs_out, 32'h33441122);
      drive(1'b1, 1'b1, 1'b0, 8'hF8, 8'h66, 1'b0, 8'hF8);
      check("mid_reset_window_lost", {31'b0, ta_viol}, 32'd1);

      // Randomized traffic, biased towards TA key writes and protected accesses.
      for (int n = 0; n < 600; n++) begin
         r = $urandom_range(0, 11);
         pick = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 5))
            0, 1, 2, 3: ra = addr_of(int'(pick));
            4:          ra = TA;
            default:    ra = 8'($urandom);
         endcase
         if (r <= 3) begin
            case ($urandom_range(0, 4))
               0, 1:    d = 8'hAA;
               2, 3:    d = 8'h55;
               default: d = 8'($urandom);
            endcase
            ta_write(d);
         end else if (r <= 6) begin
            a = ($urandom_range(0, 4) == 0) ? 8'($urandom) : addr_of(int'(pick));
            drive(1'b1, 1'b1, 1'b0, a, 8'($urandom), 1'b0, ra);
         end else if (r <= 8) begin
            a = addr_of(int'(pick)) | 8'($urandom_range(0, 7));
            drive(1'b1, 1'b1, 1'b1, a, 8'($urandom), 1'($urandom), ra);
         end else if (r == 9 && $urandom_range(0, 15) == 0) begin
            drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, ra);
         end else begin
            idle(ra);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
